// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour BCD time-of-day clock with a one-second prescaler,
// validated time/alarm loading, optional 12-hour display and a two-state
// alarm FSM (IDLE / RINGING) with a bounded ring length.
//
// Handshake: load_valid and alarm_set are sampled on every rising clk edge
// with no ready/backpressure; the command is accepted on that edge if its
// digits are legal, otherwise load_err pulses for one cycle on the next cycle.
module alarm_clock #(
    parameter int CLK_FREQ_HZ = 5000000,
    parameter int MODE_12H    = 0,
    parameter int ALARM_LEN_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [3:0] load_hour_tens,
    input  logic [3:0] load_hour_ones,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       alarm_set,
    input  logic [3:0] alarm_hour_tens,
    input  logic [3:0] alarm_hour_ones,
    input  logic [3:0] alarm_min_tens,
    input  logic [3:0] alarm_min_ones,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       pm,
    output logic       one_sec_pulse,
    output logic       alarm_out,
    output logic       load_err,
    output logic       dbg_state
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_FREQ_HZ - 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [7:0] LAST_TICK = 8'(ALARM_LEN_S - 1);
    localparam logic [3:0] RST_HT = (MODE_12H != 0) ? 4'd1 : 4'd0;
    localparam logic [3:0] RST_HO = (MODE_12H != 0) ? 4'd2 : 4'd0;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_RINGING = 1'b1;

    logic [PW-1:0] r_presc;
    logic [3:0]    r_ht, r_ho, r_mt, r_mo, r_st, r_so;
    logic [3:0]    r_al_ht, r_al_ho, r_al_mt, r_al_mo;
    logic          r_state;
    logic [7:0]    r_ring_cnt;
    logic          r_load_err;
    logic [3:0]    r_d_ht, r_d_ho, r_d_mt, r_d_mo, r_d_st, r_d_so;
    logic          r_pm;

    logic          w_tick, w_load_ok, w_alarm_ok, w_do_load, w_adv, w_match;
    logic [3:0]    w_inc_ht, w_inc_ho, w_inc_mt, w_inc_mo, w_inc_st, w_inc_so;
    logic [3:0]    w_nxt_ht, w_nxt_ho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;
    logic [4:0]    w_hbin, w_h12;
    logic [3:0]    w_dht, w_dho;
    logic          w_pm_n;

    assign w_tick        = (r_presc == P_MAX);
    assign one_sec_pulse = w_tick;
    assign w_do_load     = load_valid && w_load_ok;
    assign w_adv         = w_tick && !w_do_load;
    assign alarm_out     = (r_state == ST_RINGING);
    assign dbg_state     = r_state;
    assign load_err      = r_load_err;
    assign {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} =
           {r_d_ht, r_d_ho, r_d_mt, r_d_mo, r_d_st, r_d_so};
    assign pm            = r_pm;

    // Legality of the load and alarm digit sets (BCD, hour <= 23, min/sec <= 59)
    always_comb begin
        w_load_ok = (load_hour_tens <= 4'd2) && (load_hour_ones <= 4'd9) &&
                    !((load_hour_tens == 4'd2) && (load_hour_ones > 4'd3)) &&
                    (load_min_tens <= 4'd5) && (load_min_ones <= 4'd9) &&
                    (load_sec_tens <= 4'd5) && (load_sec_ones <= 4'd9);
        w_alarm_ok = (alarm_hour_tens <= 4'd2) && (alarm_hour_ones <= 4'd9) &&
                     !((alarm_hour_tens == 4'd2) && (alarm_hour_ones > 4'd3)) &&
                     (alarm_min_tens <= 4'd5) && (alarm_min_ones <= 4'd9);
    end

    // Current time plus one second, with BCD carries and midnight wrap
    always_comb begin
        w_inc_ht = r_ht;
        w_inc_ho = r_ho;
        w_inc_mt = r_mt;
        w_inc_mo = r_mo;
        w_inc_st = r_st;
        w_inc_so = r_so;
        if (r_so != 4'd9) begin
            w_inc_so = r_so + 4'd1;
        end else begin
            w_inc_so = 4'd0;
            if (r_st != 4'd5) begin
                w_inc_st = r_st + 4'd1;
            end else begin
                w_inc_st = 4'd0;
                if (r_mo != 4'd9) begin
                    w_inc_mo = r_mo + 4'd1;
                end else begin
                    w_inc_mo = 4'd0;
                    if (r_mt != 4'd5) begin
                        w_inc_mt = r_mt + 4'd1;
                    end else begin
                        w_inc_mt = 4'd0;
                        if ((r_ht == 4'd2) && (r_ho == 4'd3)) begin
                            w_inc_ht = 4'd0;
                            w_inc_ho = 4'd0;
                        end else if (r_ho == 4'd9) begin
                            w_inc_ht = r_ht + 4'd1;
                            w_inc_ho = 4'd0;
                        end else begin
                            w_inc_ho = r_ho + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Next internal time: a valid load wins over a coincident tick
    always_comb begin
        if (w_do_load) begin
            {w_nxt_ht, w_nxt_ho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} =
                {load_hour_tens, load_hour_ones, load_min_tens, load_min_ones,
                 load_sec_tens, load_sec_ones};
        end else if (w_adv) begin
            {w_nxt_ht, w_nxt_ho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} =
                {w_inc_ht, w_inc_ho, w_inc_mt, w_inc_mo, w_inc_st, w_inc_so};
        end else begin
            {w_nxt_ht, w_nxt_ho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} =
                {r_ht, r_ho, r_mt, r_mo, r_st, r_so};
        end
        // Alarm fires only when a real tick lands on HH:MM:00
        w_match = w_adv && alarm_en && (w_inc_st == 4'd0) && (w_inc_so == 4'd0) &&
                  ({w_inc_ht, w_inc_ho, w_inc_mt, w_inc_mo} ==
                   {r_al_ht, r_al_ho, r_al_mt, r_al_mo});
    end

    // Display hour mapping of the next time (12-hour when MODE_12H is set)
    always_comb begin
        w_hbin = ({1'b0, w_nxt_ht} * 5'd10) + {1'b0, w_nxt_ho};
        w_h12  = w_hbin;
        w_pm_n = 1'b0;
        if (w_hbin == 5'd0) begin
            w_h12 = 5'd12;
        end else if (w_hbin == 5'd12) begin
            w_pm_n = 1'b1;
        end else if (w_hbin > 5'd12) begin
            w_h12  = w_hbin - 5'd12;
            w_pm_n = 1'b1;
        end
        if (w_h12 >= 5'd10) begin
            w_dht = 4'd1;
            w_dho = 4'(w_h12 - 5'd10);
        end else begin
            w_dht = 4'd0;
            w_dho = 4'(w_h12);
        end
        if (MODE_12H == 0) begin
            w_dht  = w_nxt_ht;
            w_dho  = w_nxt_ho;
            w_pm_n = 1'b0;
        end
    end

    // Prescaler, internal time, display registers and load error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            {r_ht, r_ho, r_mt, r_mo, r_st, r_so} <= '0;
            {r_d_ht, r_d_ho} <= {RST_HT, RST_HO};
            {r_d_mt, r_d_mo, r_d_st, r_d_so} <= '0;
            r_pm       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_do_load || w_tick) r_presc <= '0;
            else                     r_presc <= r_presc + P_ONE;
            {r_ht, r_ho, r_mt, r_mo, r_st, r_so} <=
                {w_nxt_ht, w_nxt_ho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so};
            {r_d_ht, r_d_ho, r_d_mt, r_d_mo, r_d_st, r_d_so} <=
                {w_dht, w_dho, w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so};
            r_pm       <= w_pm_n;
            r_load_err <= (load_valid && !w_load_ok) || (alarm_set && !w_alarm_ok);
        end
    end

    // Stored alarm time, survives time loads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {r_al_ht, r_al_ho, r_al_mt, r_al_mo} <= '0;
        end else if (alarm_set && w_alarm_ok) begin
            {r_al_ht, r_al_ho, r_al_mt, r_al_mo} <=
                {alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones};
        end
    end

    // Alarm FSM: ring for ALARM_LEN_S ticks unless acked or disarmed first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ring_cnt <= 8'd0;
                    if (w_match) r_state <= ST_RINGING;
                end
                default: begin
                    if (!alarm_en || alarm_ack || (w_adv && (r_ring_cnt == LAST_TICK))) begin
                        r_state    <= ST_IDLE;
                        r_ring_cnt <= 8'd0;
                    end else if (w_adv) begin
                        r_ring_cnt <= r_ring_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: directed bench for alarm_clock. Two instances share all
// inputs: dut0 in 24-hour mode, dut1 in 12-hour mode, both with a 4-cycle
// second and a 3-second alarm.
module tb_alarm_clock;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [23:0] load_v;
  logic        alarm_set;
  logic [15:0] alarm_v;
  logic        alarm_en;
  logic        alarm_ack;

  logic [3:0]  so0, st0, mo0, mt0, ho0, ht0, so1, st1, mo1, mt1, ho1, ht1;
  logic        pm0, pulse0, aout0, lerr0, dbg0;
  logic        pm1, pulse1, aout1, lerr1, dbg1;
  logic [23:0] disp0, disp1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  assign disp0 = {ht0, ho0, mt0, mo0, st0, so0};
  assign disp1 = {ht1, ho1, mt1, mo1, st1, so1};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  alarm_clock #(.CLK_FREQ_HZ(4), .MODE_12H(0), .ALARM_LEN_S(3)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .load_hour_tens(load_v[23:20]), .load_hour_ones(load_v[19:16]),
    .load_min_tens(load_v[15:12]), .load_min_ones(load_v[11:8]),
    .load_sec_tens(load_v[7:4]), .load_sec_ones(load_v[3:0]),
    .alarm_set(alarm_set),
    .alarm_hour_tens(alarm_v[15:12]), .alarm_hour_ones(alarm_v[11:8]),
    .alarm_min_tens(alarm_v[7:4]), .alarm_min_ones(alarm_v[3:0]),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
    .hour_ones(ho0), .hour_tens(ht0), .pm(pm0), .one_sec_pulse(pulse0),
    .alarm_out(aout0), .load_err(lerr0), .dbg_state(dbg0)
  );

  alarm_clock #(.CLK_FREQ_HZ(4), .MODE_12H(1), .ALARM_LEN_S(3)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .load_hour_tens(load_v[23:20]), .load_hour_ones(load_v[19:16]),
    .load_min_tens(load_v[15:12]), .load_min_ones(load_v[11:8]),
    .load_sec_tens(load_v[7:4]), .load_sec_ones(load_v[3:0]),
    .alarm_set(alarm_set),
    .alarm_hour_tens(alarm_v[15:12]), .alarm_hour_ones(alarm_v[11:8]),
    .alarm_min_tens(alarm_v[7:4]), .alarm_min_ones(alarm_v[3:0]),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .hour_ones(ho1), .hour_tens(ht1), .pm(pm1), .one_sec_pulse(pulse1),
    .alarm_out(aout1), .load_err(lerr1), .dbg_state(dbg1)
  );

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    load_v     = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_alarm(input logic [15:0] v);
    alarm_v   = v;
    alarm_set = 1'b1;
    step();
    alarm_set = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_v = '0; alarm_set = 1'b0;
    alarm_v = '0; alarm_en = 1'b0; alarm_ack = 1'b0;
    #12;
    chk("rst_disp24", disp0, 24'h000000);
    chk("rst_disp12", disp1, 24'h120000);
    chk("rst_pm12", pm1, 0);
    chk("rst_pulse", pulse0, 0);
    chk("rst_aout", aout0, 0);
    chk("rst_lerr", lerr0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // one-second pulse cadence and midnight wrap
    do_load(24'h235958);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("pulse_c%0d", c), pulse0, (c % 4 == 0) ? 1 : 0);
      chk($sformatf("disp_c%0d", c), disp0, (c <= 4) ? 24'h235958 : 24'h235959);
      if (c == 5) begin
        chk("disp12_2359", disp1, 24'h115959);
        chk("pm_2359", pm1, 1);
      end
      step();
    end
    chk("wrap24", disp0, 24'h000000);
    chk("wrap12", disp1, 24'h120000);
    chk("wrap_pm", pm1, 0);

    // 12-hour mapping
    do_load(24'h115959);
    repeat (4) step();
    chk("noon24", disp0, 24'h120000);
    chk("noon12", disp1, 24'h120000);
    chk("noon_pm", pm1, 1);
    chk("pm24_zero", pm0, 0);
    do_load(24'h003000);
    chk("half12", disp1, 24'h123000);
    chk("half_pm", pm1, 0);
    do_load(24'h130500);
    chk("one12", disp1, 24'h010500);
    chk("one_pm", pm1, 1);

    // rejected loads leave time and prescaler alone
    do_load(24'h240000);
    chk("err24_pulse", lerr0, 1);
    chk("err24_time", disp0, 24'h130500);
    step();
    chk("err24_clear", lerr0, 0);
    do_load(24'h123A00);
    chk("errA_pulse", lerr0, 1);
    chk("errA_time", disp0, 24'h130500);
    step();
    chk("errA_clear", lerr0, 0);
    chk("err_presc_kept", disp0, 24'h130501);
    load_v = 24'h240000; alarm_v = 16'h2400;
    load_valid = 1'b1; alarm_set = 1'b1;
    step();
    load_valid = 1'b0; alarm_set = 1'b0;
    chk("err_both_pulse", lerr0, 1);
    step();
    chk("err_both_clear", lerr0, 0);

    // load coincident with tick
    do_load(24'h100000);
    repeat (3) step();
    chk("coin_pulse_before", pulse0, 1);
    do_load(24'h102030);
    chk("coin_time", disp0, 24'h102030);
    chk("coin_presc0", pulse0, 0);
    repeat (3) step();
    chk("coin_pulse_again", pulse0, 1);
    chk("coin_time_held", disp0, 24'h102030);
    step();
    chk("coin_advance", disp0, 24'h102031);

    // alarm set, rejected alarm keeps the stored one
    do_alarm(16'h0700);
    chk("alarm_ok", lerr0, 0);
    do_alarm(16'h0760);
    chk("alarm_bad", lerr0, 1);
    alarm_en = 1'b1;
    do_load(24'h065958);
    repeat (4) step();
    chk("pre_alarm", aout0, 0);
    repeat (4) step();
    chk("ring_time", disp0, 24'h070000);
    chk("ring_on", aout0, 1);
    chk("ring_dbg", dbg0, 1);
    repeat (4) step();
    chk("ring_s1", aout0, 1);
    repeat (4) step();
    chk("ring_s2", aout0, 1);
    repeat (3) step();
    chk("ring_s2_late", aout0, 1);
    step();
    chk("ring_end_time", disp0, 24'h070003);
    chk("ring_end", aout0, 0);

    // loading the alarm time itself does not ring
    do_load(24'h070000);
    chk("load_match_now", aout0, 0);
    repeat (4) step();
    chk("load_match_later", aout0, 0);

    // ack dismisses
    do_load(24'h065959);
    repeat (4) step();
    chk("ack_ring", aout0, 1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack_off", aout0, 0);

    // disarm dismisses
    do_load(24'h065959);
    repeat (4) step();
    chk("en_ring", aout0, 1);
    alarm_en = 1'b0;
    step();
    chk("en_off", aout0, 0);
    alarm_en = 1'b1;

    // asynchronous reset mid-ring
    do_load(24'h065959);
    repeat (4) step();
    chk("rst_ring", aout1, 1);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_aout0", aout0, 0);
    chk("rst_async_aout1", aout1, 0);
    chk("rst_async_disp24", disp0, 24'h000000);
    chk("rst_async_disp12", disp1, 24'h120000);
    #2 reset = 1'b1;
    repeat (3) step();
    chk("resume_pulse", pulse0, 1);
    step();
    chk("resume_time", disp0, 24'h000001);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alarm_clock.md
ALARM_CLOCK -- requirements
Module: alarm_clock

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 5000000: input clock cycles per second (>=2).
REQ-002 SHALL have parameter MODE_12H, default 0: 0 = 24-hour display, 1 = 12-hour display with pm flag.
REQ-003 SHALL have parameter ALARM_LEN_S, default 60: alarm duration in seconds (1..255).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load_valid  input  1  load time from load_* this cycle.
REQ-007 SHALL have ports load_hour_tens, load_hour_ones, load_min_tens, load_min_ones, load_sec_tens, load_sec_ones  input  4 each  BCD time in 24-hour form.
REQ-008 SHALL have port alarm_set  input  1  capture alarm_* this cycle.
REQ-009 SHALL have ports alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones  input  4 each  BCD alarm time, 24-hour form.
REQ-010 SHALL have port alarm_en  input  1  alarm arming level.
REQ-011 SHALL have port alarm_ack  input  1  single-cycle alarm dismiss.
REQ-012 SHALL have ports sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens  output  4 each  registered BCD display digits.
REQ-013 SHALL have port pm  output  1  afternoon flag (constant 0 when MODE_12H=0).
REQ-014 SHALL have port one_sec_pulse  output  1  one-cycle pulse per second.
REQ-015 SHALL have port alarm_out  output  1  alarm active.
REQ-016 SHALL have port load_err  output  1  one-cycle pulse on a rejected load or alarm_set.

Function
REQ-017 Prescaler SHALL count 0..CLK_FREQ_HZ-1 and wrap; one_sec_pulse SHALL be high exactly in the cycle the count equals CLK_FREQ_HZ-1.
REQ-018 Internal time SHALL be kept in 24-hour BCD and SHALL advance by one second on the edge ending a one_sec_pulse cycle.
REQ-019 Carries SHALL be: sec 59->00 increments min; min 59->00 increments hour; 23:59:59 -> 00:00:00.
REQ-020 When MODE_12H=0, outputs SHALL equal internal time; when 1, hour 00 SHALL display 12 pm=0, 01-11 as-is pm=0, 12 as 12 pm=1, 13-23 minus 12 pm=1.
REQ-021 A load SHALL be valid only if every digit is BCD, hour<=23, min<=59, sec<=59.
REQ-022 Valid load_valid SHALL replace internal time on the next edge and clear the prescaler to 0; load SHALL take priority over a coincident tick (tick discarded).
REQ-023 Invalid load_valid or alarm_set SHALL leave state unchanged and pulse load_err for one cycle, registered; coincident invalid load and alarm_set SHALL yield one pulse.
REQ-024 Valid alarm_set (hour<=23, min<=59, BCD) SHALL update the stored alarm next edge; stored alarm SHALL persist across loads.
REQ-025 Alarm FSM states: IDLE, RINGING.
REQ-026 IDLE->RINGING SHALL occur on the edge where time advances to HH:MM:00 equal to the stored alarm with alarm_en=1; loading that exact time SHALL NOT trigger.
REQ-027 In RINGING, alarm_out SHALL be 1 and an 8-bit seconds counter SHALL count ticks; RINGING->IDLE after ALARM_LEN_S ticks, on alarm_ack, or when alarm_en=0, whichever first.
REQ-028 alarm_ack in IDLE SHALL have no effect; alarm_out SHALL drop the cycle after the exiting edge.
REQ-029 A new match while RINGING SHALL be ignored (no restart).

Reset
REQ-030 reset=0 SHALL asynchronously force prescaler 0, time 00:00:00, alarm 00:00, FSM IDLE, alarm_out 0, one_sec_pulse 0, load_err 0; display 00:00:00 (MODE_12H=0) or 12:00:00 pm=0 (MODE_12H=1).
REQ-031 Reset asserted mid-ring SHALL clear alarm_out immediately; operation SHALL resume on the first rising clk after release.

Verification
REQ-032 CLK_FREQ_HZ=4, load 23:59:58, run 8 cycles -> pulses at cycles 4,8; display 23:59:59 then 00:00:00.
REQ-033 MODE_12H=1, load 11:59:59, one tick -> display 12:00:00 pm=1; load 00:30:00 -> 12:30:00 pm=0.
REQ-034 load 24:00:00 or digit 0xA -> load_err one cycle, time unchanged; load coincident with tick -> loaded value held, prescaler 0.
REQ-035 alarm 07:00, alarm_en=1, load 06:59:58, ALARM_LEN_S=3 -> alarm_out rises at 07:00:00, falls after 07:00:03.
REQ-036 ringing, alarm_ack pulse -> alarm_out 0 next cycle; ringing, reset low -> alarm_out 0 asynchronously.
